// File: rtl/cmp_share_arb_pkg.sv
// Shared types and constants for the round-robin shared comparator.
package cmp_share_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 16;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    typedef enum logic {
        OS_EMPTY = 1'b0,
        OS_FULL  = 1'b1
    } ostate_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping back to index 0.
module cmp_share_arb_rr_pick
    import cmp_share_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        if (en_i) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!any_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
                    any_o = 1'b1;
                    gnt_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
                    idx_o = IDW'((int'(ptr_i) + k) % NREQ);
                end
            end
        end
    end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin sharing of one unsigned comparator with a registered result stage.
// Optional consume/equal counters behind CMP_SHARE_ARB_STATS_EN.
module cmp_share_arb
    import cmp_share_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
`ifdef CMP_SHARE_ARB_STATS_EN
    output logic [15:0]        txn_count,
    output logic [15:0]        eq_count,
`endif
    output logic               rsp_gt,
    output logic               rsp_eq,
    output logic               rsp_lt
);

    ostate_e        state_q, state_d;
    cmp_res_t       res_q, res_d;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           accept;
    logic           pick_en;
    logic           any_gnt;
    logic [IDW-1:0] gnt_idx;
    logic [DW-1:0]  a_sel, b_sel;

    assign accept  = (state_q == OS_EMPTY) | rsp_ready;
    assign pick_en = accept & ~rst;

    cmp_share_arb_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (pick_en),
        .gnt_o (req_ready),
        .idx_o (gnt_idx),
        .any_o (any_gnt)
    );

    // The single shared comparator sees only the granted pair.
    assign a_sel = req_a[int'(gnt_idx)*DW +: DW];
    assign b_sel = req_b[int'(gnt_idx)*DW +: DW];

    always_comb begin
        res_d.gt = a_sel > b_sel;
        res_d.eq = a_sel == b_sel;
        res_d.lt = a_sel < b_sel;
    end

    assign ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OS_EMPTY: begin
                if (any_gnt) state_d = OS_FULL;
            end
            OS_FULL: begin
                if (any_gnt)        state_d = OS_FULL;
                else if (rsp_ready) state_d = OS_EMPTY;
            end
            default: state_d = OS_EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid = (state_q == OS_FULL);
        rsp_id    = id_q;
        rsp_gt    = res_q.gt;
        rsp_eq    = res_q.eq;
        rsp_lt    = res_q.lt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            id_q  <= '0;
            ptr_q <= '0;
        end else if (any_gnt) begin
            res_q <= res_d;
            id_q  <= gnt_idx;
            ptr_q <= ptr_d;
        end else if (rsp_ready) begin
            res_q <= '0;
        end
    end

`ifdef CMP_SHARE_ARB_STATS_EN
    logic [15:0] txn_q, eq_q;
    logic        consumed;

    assign consumed = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q <= '0;
            eq_q  <= '0;
        end else if (consumed) begin
            if (txn_q != 16'hFFFF) txn_q <= txn_q + 16'd1;
            if (res_q.eq && eq_q != 16'hFFFF) eq_q <= eq_q + 16'd1;
        end
    end

    assign txn_count = txn_q;
    assign eq_count  = eq_q;
`endif

endmodule

// File: tb/tb_cmp_share_arb.sv
// Self-checking bench for cmp_share_arb: directed scenarios plus a
// randomized run checked against a behavioural model.
module tb_cmp_share_arb;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_gt, rsp_eq, rsp_lt;
`ifdef CMP_SHARE_ARB_STATS_EN
    logic [15:0]        txn_count, eq_count;
`endif

    always #5 clk = ~clk;

    cmp_share_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
`ifdef CMP_SHARE_ARB_STATS_EN
        .txn_count (txn_count),
        .eq_count  (eq_count),
`endif
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .rsp_lt    (rsp_lt)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model of the result register and arbitration pointer.
    bit            m_valid;
    int            m_id;
    int            m_ptr;
    logic [DW-1:0] m_a, m_b;
    int            m_txn, m_eq;

    function automatic int pick(logic [NREQ-1:0] v, int ptr, bit acc);
        if (!acc) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        if (rst) return '0;
        g = pick(req_valid, m_ptr, !m_valid || rsp_ready);
        if (g < 0) return '0;
        return NREQ'(1) << g;
    endfunction

    // Advance one clock edge and apply it to the model; returns at edge+1.
    task automatic tick();
        int g;
        g = rst ? -1 : pick(req_valid, m_ptr, !m_valid || rsp_ready);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_id = 0; m_ptr = 0; m_txn = 0; m_eq = 0;
            m_a = '0; m_b = '0;
        end else begin
            if (m_valid && rsp_ready) begin
                if (m_txn < 65535) m_txn++;
                if (m_a == m_b && m_eq < 65535) m_eq++;
            end
            if (g >= 0) begin
                m_valid = 1;
                m_id    = g;
                m_a     = req_a[g*DW +: DW];
                m_b     = req_b[g*DW +: DW];
                m_ptr   = (g + 1) % NREQ;
            end else if (rsp_ready) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic set_req(int i, logic [DW-1:0] a, logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready got=%b want=0", req_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({rsp_valid, rsp_gt, rsp_eq, rsp_lt, req_ready} !== '0) begin
                errors++;
                $display("FAIL idle c=%0d got v=%b g=%b e=%b l=%b rdy=%b want 0",
                         c, rsp_valid, rsp_gt, rsp_eq, rsp_lt, req_ready);
            end
        end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_req(1, 16'h1234, 16'h1234);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_ready got=%b want=0010", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {1'b1, 2'd1, 3'b010}) begin
            errors++;
            $display("FAIL single_rsp got v=%b id=%0d g=%b e=%b l=%b want v=1 id=1 eq=1",
                     rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got=%b want=0", rsp_valid);
        end
    endtask

    task automatic test_fairness();
        int cnt[NREQ];
        int got;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            set_req(i, DW'(i * 3), DW'(5));
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            got = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) got = i;
            checks++;
            if ($countones(req_ready) != 1 || got != c % NREQ) begin
                errors++;
                $display("FAIL fair_grant c=%0d got=%b want idx %0d", c, req_ready, c % NREQ);
            end
            if (got >= 0) cnt[got]++;
            tick();
            checks++;
            if (rsp_id !== IDW'(c % NREQ) || rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL fair_id c=%0d got=%0d want=%0d", c, rsp_id, c % NREQ);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (cnt[i] != 2) begin
                errors++;
                $display("FAIL fair_count req=%0d got=%0d want=2", i, cnt[i]);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(0, 16'hFFFF, 16'h0001);
        for (int i = 1; i < NREQ; i++) set_req(i, 16'h0001, 16'h0002);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_first got=%b want=0001", req_ready);
        end
        tick();
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL bp_ready c=%0d got=%b want=0", c, req_ready);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {1'b1, 2'd0, 3'b100}) begin
                errors++;
                $display("FAIL bp_hold c=%0d got v=%b id=%0d g=%b e=%b l=%b want v=1 id=0 gt=1",
                         c, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_next got=%b want=0010", req_ready);
        end
        tick();
        checks++;
        if (rsp_id !== 2'd1 || rsp_lt !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_rsp got id=%0d lt=%b want id=1 lt=1", rsp_id, rsp_lt);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, 16'h0000, 16'h8000);
        set_req(3, 16'h0000, 16'h8000);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_r2 got=%b want=0100", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000 || rsp_id !== 2'd2 || rsp_lt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got rdy=%b id=%0d lt=%b want rdy=1000 id=2 lt=1",
                     req_ready, rsp_id, rsp_lt);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {1'b1, 2'd3, 3'b001}) begin
            errors++;
            $display("FAIL b2b_second got v=%b id=%0d g=%b e=%b l=%b want v=1 id=3 lt=1",
                     rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_gt, rsp_eq, rsp_lt} !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_drain got v=%b g=%b e=%b l=%b want all 0",
                     rsp_valid, rsp_gt, rsp_eq, rsp_lt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, 16'h0007, 16'h0007);
        req_valid = 4'b0100;
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        rst = 1'b1;
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL rmid_ready got=%b want=0", req_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if ({rsp_valid, rsp_gt, rsp_eq, rsp_lt} !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_rsp got v=%b g=%b e=%b l=%b want all 0",
                     rsp_valid, rsp_gt, rsp_eq, rsp_lt);
        end
`ifdef CMP_SHARE_ARB_STATS_EN
        checks++;
        if (txn_count !== 16'd0 || eq_count !== 16'd0) begin
            errors++;
            $display("FAIL rmid_stats got txn=%0d eq=%0d want 0", txn_count, eq_count);
        end
`endif
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_ptr got=%b want=0001", req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] er;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            er = exp_ready();
            checks++;
            if (req_ready !== er) begin
                errors++;
                $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, er);
            end
            tick();
            checks++;
            if (rsp_valid !== m_valid
                || (m_valid && rsp_id !== IDW'(m_id))
                || rsp_gt !== (m_valid && m_a > m_b)
                || rsp_eq !== (m_valid && m_a == m_b)
                || rsp_lt !== (m_valid && m_a < m_b)) begin
                errors++;
                $display("FAIL rnd_rsp c=%0d got v=%b id=%0d g=%b e=%b l=%b want v=%0d id=%0d a=%h b=%h",
                         c, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, m_valid, m_id, m_a, m_b);
            end
`ifdef CMP_SHARE_ARB_STATS_EN
            checks++;
            if (txn_count !== 16'(m_txn) || eq_count !== 16'(m_eq)) begin
                errors++;
                $display("FAIL rnd_stats c=%0d got txn=%0d eq=%0d want txn=%0d eq=%0d",
                         c, txn_count, eq_count, m_txn, m_eq);
            end
`endif
            // Pending requesters hold their pair; others may change or drop.
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || er[i] || rst) begin
                    logic [DW-1:0] a;
                    a = DW'($urandom);
                    req_valid[i] = $urandom_range(0, 1);
                    set_req(i, a, ($urandom_range(0, 3) == 0) ? a : DW'($urandom));
                end
            end
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        m_valid = 0; m_id = 0; m_ptr = 0; m_txn = 0; m_eq = 0;
        m_a = '0; m_b = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_share_arb.md
Name: cmp_share_arb

Overview:
- Shares one unsigned magnitude comparator between NREQ requesters using round-robin arbitration.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- The winning pair is compared and the result is registered into a single-entry output stage with valid/ready backpressure, tagged with the requester index.
- Sits between the operand producers and the shared comparator datapath; full throughput is one compare per cycle.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 16, operand width in bits.
- IDW, $clog2(NREQ), requester-index width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i presents an operand pair.
- req_ready  output  NREQ  bit i: requester i's pair is accepted this cycle; one-hot or zero.
- req_a  input  NREQ*DW  operand a; requester i occupies bits [i*DW +: DW].
- req_b  input  NREQ*DW  operand b; same packing as req_a.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_gt  output  1  a > b (unsigned).
- rsp_eq  output  1  a == b.
- rsp_lt  output  1  a < b (unsigned).

Behaviour:
- Reset (rst=1 at a clk edge): rsp_valid, rsp_id, rsp_gt, rsp_eq and rsp_lt = 0; RR pointer = 0. req_ready is combinational and is all-zero while rst=1.
- Output-stage states:
  - EMPTY (rsp_valid=0)
  - FULL (rsp_valid=1)
- accept = !rsp_valid | rsp_ready.
- Grant: when accept=1 and any req_valid is set, pick the first set req_valid searching from the pointer upward, wrapping NREQ-1 -> 0. Only the granted requester sees req_ready=1. req_ready may depend combinationally on req_valid and rsp_ready; it must not depend on req_a or req_b.
- On a grant edge:
  - Load the result register with the comparison of the granted pair.
  - Set rsp_valid=1 and rsp_id=grant index.
  - Set pointer = (grant+1) mod NREQ.
- Latency: request accepted in cycle N -> result visible in cycle N+1.
- No grant and rsp_ready=1 while FULL: rsp_valid -> 0 and all three flags clear to 0.
- FULL and rsp_ready=0: the register and pointer hold, and req_ready = 0.
- FULL, rsp_ready=1 and a request pending: consume and reload in the same edge (back-to-back). rsp_valid stays 1.
- The pointer advances only on a grant; idle cycles leave it unchanged.
- Invariant: when rsp_valid=1, exactly one of gt/eq/lt is 1. When rsp_valid=0, all three are 0.
- Requester rules: must hold req_valid and its operands stable until req_ready. Dropping req_valid early is legal and simply forfeits the slot.
- Reset mid-transaction discards any held result. No partial state survives reset.

Optional Feature:
- Macro: CMP_SHARE_ARB_STATS_EN.
- Defined:
  - Adds output port txn_count (16 bits): number of results consumed (rsp_valid & rsp_ready).
  - Saturates at 16'hFFFF and resets to 0.
  - Adds output port eq_count (16 bits): same rules, counting only consumed results with rsp_eq=1.
- Undefined: both ports and their counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package cmp_share_arb_pkg holds:
  - localparam defaults for DW and NREQ.
  - typedef cmp_res_t: packed struct {gt, eq, lt}.
  - a function clog2 for IDW.
- Sub-module cmp_share_arb_rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, grant index, any_grant.
- The comparison itself is inline in the parent.

Test Plan:
- Reset then idle: no req_valid for 5 cycles -> rsp_valid=0, flags=0, req_ready=0.
- Single requester: req1 with a=16'h1234, b=16'h1234 -> req_ready[1] in cycle N; in cycle N+1, rsp_valid=1, rsp_id=1, rsp_eq=1.
- Fairness: all 4 requesters valid continuously with rsp_ready=1 -> grants cycle 0,1,2,3,0,… and each requester gets exactly 2 of every 8 grants.
- Backpressure: req0 with a=16'hFFFF, b=16'h0001 and rsp_ready=0 for 3 cycles:
  - rsp_gt=1 held throughout, req_ready=0, pointer frozen.
  - After rsp_ready=1, the next grant goes to req1 (pointer=1).
- Back-to-back plus idle drain: req2 then req3 on consecutive cycles, a=16'h0000, b=16'h8000 -> rsp_lt=1 on two consecutive cycles with rsp_id=2, then 3. rsp_valid then falls to 0 and the flags clear.
- Reset mid-operation: rst=1 while FULL -> next cycle rsp_valid=0 and pointer=0. With CMP_SHARE_ARB_STATS_EN defined, txn_count=0.
